// File: rtl/xor_stream_cipher_nch_if.sv
// Bus bundle for xor_stream_cipher_nch.
// Enable macro: KEYSTREAM_RESYNC_EN adds the per-channel i_ch_resync signal.
// Signals (named from the cipher's point of view):
//   i_cfg_en    config chain shift enable; all channels are frozen while it is high
//   i_cfg       config chain serial input, loaded LSB-first
//   o_cfg       config chain serial output (chain bit 0)
//   i_ch_en     per-channel enable                        [N_CH]
//   i_din       per-channel plaintext/ciphertext bit      [N_CH]
//   o_dout      per-channel XORed bit                     [N_CH]
//   i_ch_resync per-channel LFSR reseed (macro only)      [N_CH]
//   o_heartbeat free-running activity indicator           [HB_W]
interface xor_stream_cipher_nch_if #(
  parameter int unsigned N_CH = 2,
  parameter int unsigned HB_W = 3
);
  logic            i_cfg_en;
  logic            i_cfg;
  logic            o_cfg;
  logic [N_CH-1:0] i_ch_en;
  logic [N_CH-1:0] i_din;
  logic [N_CH-1:0] o_dout;
`ifdef KEYSTREAM_RESYNC_EN
  logic [N_CH-1:0] i_ch_resync;
`endif
  logic [HB_W-1:0] o_heartbeat;

`ifdef KEYSTREAM_RESYNC_EN
  modport master (output i_cfg_en, i_cfg, i_ch_en, i_din, i_ch_resync,
                  input  o_cfg, o_dout, o_heartbeat);
  modport slave  (input  i_cfg_en, i_cfg, i_ch_en, i_din, i_ch_resync,
                  output o_cfg, o_dout, o_heartbeat);
`else
  modport master (output i_cfg_en, i_cfg, i_ch_en, i_din,
                  input  o_cfg, o_dout, o_heartbeat);
  modport slave  (input  i_cfg_en, i_cfg, i_ch_en, i_din,
                  output o_cfg, o_dout, o_heartbeat);
`endif
endinterface

// File: rtl/xor_stream_cipher_nch.sv
// N-channel Galois-LFSR keystream XOR stream cipher.
// Each channel has its own LFSR, seed and tap mask; seeds and taps for all
// channels live in one serial config chain and reach the LFSRs only on the
// load cycle that follows a shift burst.
// Enable macro: KEYSTREAM_RESYNC_EN adds per-channel reseed (bus.i_ch_resync).
// Ports:
//   i_clk  clock, all logic rising-edge
//   i_rst  synchronous active-high reset
//   bus    xor_stream_cipher_nch_if slave (config chain, channel data/enables,
//          registered o_dout / o_cfg, heartbeat)
module xor_stream_cipher_nch #(
  parameter int unsigned       LFSR_W   = 16,
  parameter int unsigned       N_CH     = 2,
  parameter int unsigned       HB_W     = 3,
  parameter int unsigned       HB_DIV_W = 20,
  parameter logic [LFSR_W-1:0] SEED_RST = LFSR_W'(16'hACE1),
  parameter logic [LFSR_W-1:0] TAPS_RST = LFSR_W'(16'hB400)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  xor_stream_cipher_nch_if.slave bus
);

  localparam int unsigned CH_W  = 2 * LFSR_W;
  localparam int unsigned CFG_W = N_CH * CH_W;
  // All-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED_RST == '0) ? LFSR_W'(1) : SEED_RST;

  typedef enum logic {ST_RUN, ST_SHIFT} state_e;

  state_e                        r_state;
  state_e                        w_state_nxt;
  logic                          w_load;
  logic [CFG_W-1:0]              r_cfg;
  logic [N_CH-1:0][LFSR_W-1:0]   r_lfsr;
  logic [N_CH-1:0][LFSR_W-1:0]   w_lfsr_nxt;
  logic [N_CH-1:0]               r_dout;
  logic [N_CH-1:0]               w_dout_nxt;
  logic [HB_DIV_W-1:0]           r_cnt;

  function automatic logic [LFSR_W-1:0] nz_seed(input logic [LFSR_W-1:0] s);
    return (s == '0) ? LFSR_W'(1) : s;
  endfunction

  // Shift/run tracker; the exit from a shift burst is the load cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_RUN:   if (bus.i_cfg_en) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (!bus.i_cfg_en) begin
                  w_state_nxt = ST_RUN;
                  w_load      = 1'b1;
                end
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  // Per-channel keystream next state; dout is 0 unless the channel ran this cycle.
  always_comb begin
    w_lfsr_nxt = r_lfsr;
    w_dout_nxt = '0;
    for (int c = 0; c < int'(N_CH); c++) begin
      if (bus.i_cfg_en) begin
        w_lfsr_nxt[c] = r_lfsr[c];
      end else if (w_load) begin
        w_lfsr_nxt[c] = nz_seed(r_cfg[c*CH_W +: LFSR_W]);
`ifdef KEYSTREAM_RESYNC_EN
      end else if (bus.i_ch_resync[c]) begin
        w_lfsr_nxt[c] = nz_seed(r_cfg[c*CH_W +: LFSR_W]);
`endif
      end else if (bus.i_ch_en[c]) begin
        w_dout_nxt[c] = bus.i_din[c] ^ r_lfsr[c][0];
        w_lfsr_nxt[c] = (r_lfsr[c] >> 1) ^
                        (r_lfsr[c][0] ? r_cfg[c*CH_W+LFSR_W +: LFSR_W] : '0);
      end
    end
  end

  // Config chain, LFSRs, output bits and heartbeat prescaler.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cfg  <= {N_CH{TAPS_RST, SEED_RST}};
      r_lfsr <= {N_CH{SEED_EFF}};
      r_dout <= '0;
      r_cnt  <= '0;
    end else begin
      if (bus.i_cfg_en) r_cfg <= {bus.i_cfg, r_cfg[CFG_W-1:1]};
      r_lfsr <= w_lfsr_nxt;
      r_dout <= w_dout_nxt;
      r_cnt  <= r_cnt + HB_DIV_W'(1);
    end
  end

  assign bus.o_cfg       = r_cfg[0];
  assign bus.o_dout      = r_dout;
  assign bus.o_heartbeat = r_cnt[HB_DIV_W-1 -: HB_W];

endmodule

// File: tb/tb_xor_stream_cipher_nch.sv
// Directed self-checking bench for xor_stream_cipher_nch (N_CH=2, LFSR_W=16,
// HB_W=3, HB_DIV_W=4). Instance B shares A's config inputs and takes A.dout
// as its din, so the two always hold identical configuration.
module tb_xor_stream_cipher_nch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  xor_stream_cipher_nch_if #(.N_CH(2), .HB_W(3)) bus_a ();
  xor_stream_cipher_nch_if #(.N_CH(2), .HB_W(3)) bus_b ();

  logic [1:0] b_ch_en;
  assign bus_b.i_cfg_en = bus_a.i_cfg_en;
  assign bus_b.i_cfg    = bus_a.i_cfg;
  assign bus_b.i_din    = bus_a.o_dout;
  assign bus_b.i_ch_en  = b_ch_en;
`ifdef KEYSTREAM_RESYNC_EN
  assign bus_b.i_ch_resync = 2'b00;
`endif

  xor_stream_cipher_nch #(.LFSR_W(16), .N_CH(2), .HB_W(3), .HB_DIV_W(4)) dut_a (
    .i_clk(clk), .i_rst(rst), .bus(bus_a));
  xor_stream_cipher_nch #(.LFSR_W(16), .N_CH(2), .HB_W(3), .HB_DIV_W(4)) dut_b (
    .i_clk(clk), .i_rst(rst), .bus(bus_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Shift n bits of v LSB-first; cfg_o must replay prior, then the early bits of v.
  task automatic shift_cfg(input logic [127:0] v, input int n, input logic [63:0] prior,
                           input bit do_chk);
    logic [191:0] seq;
    seq = {v, prior};
    for (int i = 0; i < n; i++) begin
      if (do_chk) chk("cfg_o_replay", 64'(bus_a.o_cfg), 64'(seq[i]));
      bus_a.i_cfg_en = 1'b1;
      bus_a.i_cfg    = v[i];
      tick();
    end
    bus_a.i_cfg_en = 1'b0;
    bus_a.i_cfg    = 1'b0;
  endtask

  // Load cycle: channels disabled, LFSRs take their seeds, dout forced low.
  task automatic do_load();
    bus_a.i_ch_en = 2'b00;
    b_ch_en       = 2'b00;
    tick();
    chk("load_dout", 64'(bus_a.o_dout), 64'd0);
  endtask

  initial begin
    logic [11:0]  e_ks;
    logic [15:0]  b400;
    logic [15:0]  s1;
    logic [5:0]   e_ace1;
    logic [63:0]  cur_cfg;
    logic [127:0] v;
    logic [1:0]   d [0:255];
    logic         exp1;

    e_ks   = 12'b1000_0000_0001;   // seed 0001 / taps B400, bit i = cycle i+1
    b400   = 16'hB400;
    e_ace1 = 6'b100001;            // seed ACE1 / taps B400, first six bits
    bus_a.i_cfg_en = 1'b0;
    bus_a.i_cfg    = 1'b0;
    bus_a.i_ch_en  = 2'b00;
    bus_a.i_din    = 2'b00;
`ifdef KEYSTREAM_RESYNC_EN
    bus_a.i_ch_resync = 2'b00;
`endif
    b_ch_en = 2'b00;

    // 1: reset values
    tick(); tick();
    chk("rst_dout", 64'(bus_a.o_dout), 64'd0);
    chk("rst_hb",   64'(bus_a.o_heartbeat), 64'd0);
    chk("rst_cfg_o", 64'(bus_a.o_cfg), 64'd1);
    rst = 1'b0;

    // 2: known keystream from seed 0001, taps B400
    cur_cfg = {16'hB400, 16'hACE1, 16'hB400, 16'hACE1};
    v = 128'({16'hB400, 16'hACE1, 16'hB400, 16'h0001});
    shift_cfg(v, 64, cur_cfg, 1'b1);
    cur_cfg = v[63:0];
    do_load();
    bus_a.i_ch_en = 2'b01;
    bus_a.i_din   = 2'b00;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("ks_seed1", 64'(bus_a.o_dout[0]), 64'(e_ks[i]));
    end

    // 4: 128-bit chain shift; final chain = ch1 seed BEEF taps DEAD, ch0 seed B400 taps 0
    bus_a.i_ch_en = 2'b00;
    v = 128'hDEADBEEF_0000B400_CAFEF00D_12345678;
    shift_cfg(v, 128, cur_cfg, 1'b1);
    chk("cfg_o_final", 64'(bus_a.o_cfg), 64'(v[64]));
    cur_cfg = v[127:64];
    do_load();
    bus_a.i_ch_en = 2'b11;
    bus_a.i_din   = 2'b00;
    s1 = 16'hBEEF;
    for (int i = 0; i < 20; i++) begin
      tick();
      exp1 = s1[0];
      s1   = (s1 >> 1) ^ (s1[0] ? 16'hDEAD : 16'h0000);
      chk("ks_ch1", 64'(bus_a.o_dout[1]), 64'(exp1));
      chk("ks_ch0_taps0", 64'(bus_a.o_dout[0]), (i < 16) ? 64'(b400[i]) : 64'd0);
    end

    // 3: round trip A encrypts, B decrypts one clock behind
    shift_cfg(128'(cur_cfg), 64, cur_cfg, 1'b0);
    do_load();
    for (int t = 0; t < 256; t++) d[t] = 2'($urandom_range(0, 3));
    for (int t = 0; t <= 256; t++) begin
      bus_a.i_ch_en = 2'b11;
      bus_a.i_din   = (t < 256) ? d[t] : 2'b00;
      b_ch_en       = (t >= 1) ? 2'b11 : 2'b00;
      tick();
      if (t >= 1) chk("round_trip", 64'(bus_b.o_dout), 64'(d[t-1]));
    end
    bus_a.i_ch_en = 2'b00;
    bus_a.i_din   = 2'b00;
    b_ch_en       = 2'b00;

    // 5: zero seed loads 1; a 5-clock enable gap leaves the sequence unbroken
    v = 128'({16'hB400, 16'hACE1, 16'hB400, 16'h0000});
    shift_cfg(v, 64, cur_cfg, 1'b1);
    cur_cfg = v[63:0];
    do_load();
    bus_a.i_ch_en = 2'b01;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("zero_seed_ks", 64'(bus_a.o_dout[0]), 64'(e_ks[i]));
    end
    bus_a.i_ch_en = 2'b00;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_dout", 64'(bus_a.o_dout), 64'd0);
    end
    bus_a.i_ch_en = 2'b01;
    for (int i = 4; i < 12; i++) begin
      tick();
      chk("resume_ks", 64'(bus_a.o_dout[0]), 64'(e_ks[i]));
    end

    // 6: reset after 10 shifted bits discards the pending load
    bus_a.i_ch_en  = 2'b00;
    bus_a.i_cfg_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus_a.i_cfg = 1'($urandom_range(0, 1));
      tick();
    end
    rst = 1'b1;
    tick();
    chk("midrst_cfg_o", 64'(bus_a.o_cfg), 64'd1);
    chk("midrst_dout",  64'(bus_a.o_dout), 64'd0);
    chk("midrst_hb",    64'(bus_a.o_heartbeat), 64'd0);
    rst = 1'b0;
    bus_a.i_cfg_en = 1'b0;
    bus_a.i_ch_en  = 2'b01;
    for (int n = 1; n <= 20; n++) begin
      if (n == 7) bus_a.i_ch_en = 2'b00;
      tick();
      if (n <= 6) chk("post_rst_ks", 64'(bus_a.o_dout[0]), 64'(e_ace1[n-1]));
      chk("heartbeat", 64'(bus_a.o_heartbeat), 64'((n % 16) / 2));
    end

`ifdef KEYSTREAM_RESYNC_EN
    // resync restarts channel 0 at its seed (ACE1 after reset)
    bus_a.i_ch_en = 2'b01;
    tick(); tick(); tick();
    bus_a.i_ch_resync = 2'b01;
    tick();
    chk("resync_dout", 64'(bus_a.o_dout), 64'd0);
    bus_a.i_ch_resync = 2'b00;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("resync_ks", 64'(bus_a.o_dout[0]), 64'(e_ace1[i]));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
